noc_dfd_tracer: RTL
===================

# noc_dfd_tracer

Parametrised Design-for-Debug trigger and trace-capture unit for the NoC top. It watches the per-endpoint flit streams and fires a trigger on a masked flit match, a flit-count threshold, or a network-wide match. It records time-stamped trace words into a circular buffer, holding pre-trigger history and a programmable post-trigger window, and a debug host drains the buffer. It replaces the fixed single-word `trigger`/`trace` pair with multi-endpoint, multi-mode capture.

## Interface
- `NE`, 16: number of monitored endpoints (≥2).
- `Fw`, 38: flit width; bit `Fw-1` is the header flag.
- `TRACEw`, 32: trace word width.
- `TSw`, 8: timestamp field width.
- `DEPTH`, 16: trace buffer entries (power of two, ≥4).
- `POST_TRIG`, 8: entries captured from the trigger onward (1 ≤ `POST_TRIG` ≤ `DEPTH`).
- `CNTw`, 16: threshold counter width.
- `EPw`, derived as log2(`NE`).
- `clk`  in  1  clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `flit_in_all`  in  NE*Fw  monitored flits; endpoint i occupies `[i*Fw +: Fw]`.
- `flit_in_wr_all`  in  NE  per-endpoint flit valid.
- `arm`  in  1  single-cycle pulse: load config, clear buffer and flags, enter ARMED.
- `cfg_mode`  in  2  0 = selected-endpoint match, 1 = count threshold, 2 = any-endpoint match, 3 = disabled.
- `cfg_ep_sel`  in  EPw  selected endpoint for modes 0/1.
- `cfg_match_value`, `cfg_match_mask`  in  Fw each  match when `(flit & mask) == (value & mask)`.
- `cfg_threshold`  in  CNTw  flit count for mode 1; a value of 0 is treated as 1.
- `trace_rd`  in  1  pop head entry; ignored when empty.
- `trigger`  out  1  trigger status level.
- `trace`  out  TRACEw  buffer head (first-word fall-through).
- `trace_valid`  out  1  buffer non-empty.
- `trace_done`  out  1  post-trigger window complete.
- `overflow`  out  1  sticky; set when any entry was discarded.

## Operation
- **Config sampling:** all `cfg_*` inputs are registered on `arm`. Changes while armed have no effect.
- **States and transitions:**
  - IDLE → ARMED on `arm`.
  - ARMED → TRIG on a trigger event.
  - TRIG → DONE when the post-trigger count reaches `POST_TRIG`.
  - `arm` in any state → ARMED, with buffer, counters, `trigger`, `overflow` and `trace_done` cleared.
  - Mode 3: stays ARMED, never triggers, still captures.
- **Capture source:**
  - Modes 0/1: endpoint `cfg_ep_sel`. Mode 1 captures every flit on it; mode 0 captures every header flit on it.
  - Mode 2: lowest-index endpoint with `wr` set and a match.
  - Mode 3: selected endpoint, all flits.
- **Trigger events:**
  - Mode 0: header flit on the selected endpoint that matches.
  - Mode 1: the Nth flit on the selected endpoint while ARMED, where N = threshold.
  - Mode 2: any endpoint match, header or not.
- **Trace word:** `{ts[TSw-1:0], ep[EPw-1:0], flit[TRACEw-TSw-EPw-1:0]}`, using the low flit bits.
  - `ts` is a free-running `TSw`-bit counter that wraps and is cleared only by `reset`.
- **Captures by state:** allowed in ARMED and TRIG. In DONE and IDLE nothing is written.
- **Post-trigger window:** the triggering flit is post-trigger entry #1. With `POST_TRIG`=1, the state goes ARMED → DONE through TRIG in consecutive cycles, and no further entry is written.
- **Buffer full:** a write with no read discards the oldest entry and sets `overflow`. Write and read together when full pops the old head and writes the new entry, with no discard and count unchanged.
- **Buffer empty:** `trace_rd` has no effect.
- **Reads:** `trace_rd` is legal in any state.

## Timing
- **Reset values:** state IDLE; `trigger`, `trace_valid`, `trace_done`, `overflow` all 0; `trace` = 0; `ts` = 0; buffer empty.
- **Capture latency:** flit valid at edge t appears on `trace`/`trace_valid` after edge t+1, when the buffer was empty.
- **Trigger:** event at edge t → `trigger` is 1 after edge t+1 and holds until `arm` or `reset`.
- **Done:** `trace_done` rises the cycle after the `POST_TRIG`-th post-trigger write.
- **Pop:** `trace_rd` at edge t → next entry (or `trace_valid` = 0) after edge t.
- **`arm` with a simultaneous flit:** the clear wins and the flit is not captured.
- **Reset mid-capture:** immediate return to reset values.

## Test plan
- **Mode 0 trigger:** `NE`=16, `cfg_ep_sel`=5, mask=0xFF, value=0x3C. Send header flit low byte 0x3C on ep5 at cycle 10 → `trigger`=1 at cycle 11; trace entry ep field=5, flit bits=0x3C.
- **Mode 1 threshold:** threshold=4, flits on ep2 at cycles 3,4,6,9 → `trigger` rises at cycle 10; threshold=0 → trigger on the 1st flit.
- **Mode 2 priority:** eps 3 and 7 match in the same cycle → single entry with ep=3; `trigger` next cycle.
- **Pre-trigger wrap:** `DEPTH`=16, 20 flits in ARMED → `overflow`=1; the head holds the 5th flit's timestamp.
- **Window close:** `POST_TRIG`=8, then `trace_done`=1 after the 8th post entry; later flits are not captured.
- **Drain and re-arm:** draining 16 entries gives `trace_valid`=0 after the 16th pop. `arm` while in DONE clears `trigger`/`overflow`/`trace_done`. Async `reset` asserted mid-TRIG clears all outputs without waiting for a clock edge.

Source files
------------

// File: rtl/noc_dfd_tracer.sv
// DFD trigger and trace-capture unit: watches NE flit streams, fires a trigger on
// match / count / network-wide match, and records time-stamped words in a circular buffer.
module noc_dfd_tracer #(
  parameter int NE        = 16,
  parameter int Fw        = 38,
  parameter int TRACEw    = 32,
  parameter int TSw       = 8,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8,
  parameter int CNTw      = 16,
  parameter int EPw       = $clog2(NE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NE*Fw-1:0]  flit_in_all,
  input  logic [NE-1:0]     flit_in_wr_all,
  input  logic              arm,
  input  logic [1:0]        cfg_mode,
  input  logic [EPw-1:0]    cfg_ep_sel,
  input  logic [Fw-1:0]     cfg_match_value,
  input  logic [Fw-1:0]     cfg_match_mask,
  input  logic [CNTw-1:0]   cfg_threshold,
  input  logic              trace_rd,
  output logic              trigger,
  output logic [TRACEw-1:0] trace,
  output logic              trace_valid,
  output logic              trace_done,
  output logic              overflow
);
  localparam int PW  = TRACEw - TSw - EPw;
  localparam int AW  = $clog2(DEPTH);
  localparam int PCw = $clog2(POST_TRIG + 1);
  localparam logic [PCw-1:0] POST_LIM = PCw'(POST_TRIG);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, TRIG = 2'd2, DONE = 2'd3} state_t;

  state_t            state;
  logic [1:0]        mode;
  logic [EPw-1:0]    ep_sel;
  logic [Fw-1:0]     match_value;
  logic [Fw-1:0]     match_mask;
  logic [CNTw-1:0]   threshold;
  logic [CNTw-1:0]   flit_cnt;
  logic [PCw-1:0]    post_cnt;
  logic [TSw-1:0]    ts;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [TRACEw-1:0] mem [DEPTH];

  logic [Fw-1:0]   sel_flit;
  logic            sel_wr;
  logic            any_hit;
  logic [EPw-1:0]  any_ep;
  logic [Fw-1:0]   any_flit;
  logic            cap;
  logic            ev;
  logic [EPw-1:0]  cap_ep;
  logic [Fw-1:0]   cap_flit;
  logic [CNTw-1:0] cnt_inc;
  logic [CNTw-1:0] thr_eff;
  logic            full;
  logic            wr_en;
  logic            rd_en;

  function automatic logic flit_match(input logic [Fw-1:0] f, input logic [Fw-1:0] v,
                                      input logic [Fw-1:0] m);
    return (f & m) == (v & m);
  endfunction

  // Capture source and trigger event for the configured mode
  always_comb begin
    sel_flit = flit_in_all[int'(ep_sel)*Fw +: Fw];
    sel_wr   = flit_in_wr_all[ep_sel];
    cnt_inc  = flit_cnt + CNTw'(1);
    thr_eff  = (threshold == '0) ? CNTw'(1) : threshold;
    any_hit  = 1'b0;
    any_ep   = '0;
    any_flit = '0;
    // Scan downward so the lowest matching endpoint is the one left standing
    for (int i = NE - 1; i >= 0; i--) begin
      if (flit_in_wr_all[i] && flit_match(flit_in_all[i*Fw +: Fw], match_value, match_mask)) begin
        any_hit  = 1'b1;
        any_ep   = EPw'(i);
        any_flit = flit_in_all[i*Fw +: Fw];
      end else begin
        any_hit  = any_hit;
      end
    end
    cap      = 1'b0;
    ev       = 1'b0;
    cap_ep   = ep_sel;
    cap_flit = sel_flit;
    case (mode)
      2'd0: begin
        cap = sel_wr && sel_flit[Fw-1];
        ev  = cap && flit_match(sel_flit, match_value, match_mask);
      end
      2'd1: begin
        cap = sel_wr;
        ev  = sel_wr && (cnt_inc == thr_eff);
      end
      2'd2: begin
        cap      = any_hit;
        ev       = any_hit;
        cap_ep   = any_ep;
        cap_flit = any_flit;
      end
      default: begin
        cap = sel_wr;
        ev  = 1'b0;
      end
    endcase
    full  = (count == FULL_CNT);
    wr_en = !arm && cap && ((state == ARMED) || ((state == TRIG) && (post_cnt < POST_LIM)));
    rd_en = !arm && trace_rd && (count != '0);
  end

  // Free-running timestamp, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts <= '0;
    else       ts <= ts + TSw'(1);
  end

  // Control state, configuration, buffer pointers and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mode        <= 2'd0;
      ep_sel      <= '0;
      match_value <= '0;
      match_mask  <= '0;
      threshold   <= '0;
      flit_cnt    <= '0;
      post_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      trigger     <= 1'b0;
      trace_done  <= 1'b0;
      overflow    <= 1'b0;
    end else if (arm) begin
      state       <= ARMED;
      mode        <= cfg_mode;
      ep_sel      <= cfg_ep_sel;
      match_value <= cfg_match_value;
      match_mask  <= cfg_match_mask;
      threshold   <= cfg_threshold;
      flit_cnt    <= '0;
      post_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      trigger     <= 1'b0;
      trace_done  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      // A write into a full buffer retires the head, whether or not it was read
      if (rd_en || (wr_en && full)) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !rd_en && !full) count <= count + (AW+1)'(1);
      else if (rd_en && !wr_en)     count <= count - (AW+1)'(1);
      if (wr_en && full && !rd_en) overflow <= 1'b1;
      case (state)
        ARMED: begin
          if ((mode == 2'd1) && sel_wr) flit_cnt <= cnt_inc;
          if (ev) begin
            state    <= TRIG;
            trigger  <= 1'b1;
            post_cnt <= PCw'(1);
          end
        end
        TRIG: begin
          if (post_cnt >= POST_LIM) begin
            state      <= DONE;
            trace_done <= 1'b1;
          end else if (cap) begin
            post_cnt <= post_cnt + PCw'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Trace storage; validity is tracked by count, so no reset is needed
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {ts, cap_ep, cap_flit[PW-1:0]};
  end

  assign trace_valid = (count != '0);
  assign trace       = trace_valid ? mem[rd_ptr] : '0;

endmodule
